operand_stage: RTL and testbench

ID/EX operand-fetch pipeline stage sitting directly downstream of the register file. It captures the two register read values plus decoded control, and resolves RAW hazards against the EX/MEM and MEM/WB stages by forwarding or stalling. It presents a registered, hazard-free operand bundle to the execute stage. It also inserts bubbles on load-use stalls and branch flushes, and keeps a saturating stall counter.

---
 rtl/pipe_pkg.sv | 54 +++++
 rtl/operand_stage_hazard_detect.sv | 52 +++++
 rtl/operand_stage.sv | 111 +++++++++++
 tb/tb_operand_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX operand stage: index/data widths,
// the PC register index, forward-select encoding and the EX bundle layout.
package pipe_pkg;

    localparam int REG_W     = 4;
    localparam int DATA_W    = 32;
    localparam int EX_CTRL_W = 10;

    localparam logic [REG_W-1:0] PC_REG = 4'hF;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memtoreg;
        logic [REG_W-1:0]     rd;
        logic [EX_CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    opa;
        logic [DATA_W-1:0]    opb;
    } ex_bundle_t;

    // RAW match of one source against one producer; r15 reads PC+8 and never matches.
    function automatic logic raw_hit(
        input logic             id_valid,
        input logic             use_src,
        input logic             prod_valid,
        input logic             prod_write,
        input logic [REG_W-1:0] prod_rd,
        input logic [REG_W-1:0] src
    );
        return id_valid & use_src & prod_valid & prod_write &
               (prod_rd == src) & (src != PC_REG);
    endfunction

    function automatic logic [DATA_W-1:0] sel_operand(
        input fwd_sel_t          sel,
        input logic [DATA_W-1:0] rf_val,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] wb_val
    );
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return rf_val;
        endcase
    endfunction

endpackage

// File: rtl/operand_stage_hazard_detect.sv
// Combinational RAW hazard resolution: per-source forward selects and stall.
// OPERAND_FORWARD_EN selects bypassing; without it every in-flight producer stalls.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra1,
    input  logic [REG_W-1:0] id_ra2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_valid,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             flush,
    output fwd_sel_t         fwd1,
    output fwd_sel_t         fwd2,
    output logic             stall
);

    logic ld1, ld2, mem1, mem2, wb1, wb2;

    assign ld1  = raw_hit(id_valid, id_use1, ex_valid, ex_regwrite & ex_memtoreg, ex_rd, id_ra1);
    assign ld2  = raw_hit(id_valid, id_use2, ex_valid, ex_regwrite & ex_memtoreg, ex_rd, id_ra2);
    assign mem1 = raw_hit(id_valid, id_use1, mem_valid, mem_regwrite, mem_rd, id_ra1);
    assign mem2 = raw_hit(id_valid, id_use2, mem_valid, mem_regwrite, mem_rd, id_ra2);
    assign wb1  = raw_hit(id_valid, id_use1, wb_valid, wb_regwrite, wb_rd, id_ra1);
    assign wb2  = raw_hit(id_valid, id_use2, wb_valid, wb_regwrite, wb_rd, id_ra2);

`ifdef OPERAND_FORWARD_EN
    // EX/MEM holds the younger producer, so it is checked first.
    assign fwd1  = mem1 ? FWD_MEM : (wb1 ? FWD_WB : FWD_RF);
    assign fwd2  = mem2 ? FWD_MEM : (wb2 ? FWD_WB : FWD_RF);
    assign stall = (ld1 | ld2) & ~flush;
`else
    logic alu1, alu2;

    assign alu1  = raw_hit(id_valid, id_use1, ex_valid, ex_regwrite & ~ex_memtoreg, ex_rd, id_ra1);
    assign alu2  = raw_hit(id_valid, id_use2, ex_valid, ex_regwrite & ~ex_memtoreg, ex_rd, id_ra2);
    assign fwd1  = FWD_RF;
    assign fwd2  = FWD_RF;
    // WB is included: the register file writes on the same edge it would be read.
    assign stall = (ld1 | ld2 | alu1 | alu2 | mem1 | mem2 | wb1 | wb2) & ~flush;
`endif

endmodule

// File: rtl/operand_stage.sv
// ID/EX pipeline register with operand selection, bubble insertion and a
// saturating stall counter. Bypassing is enabled by defining OPERAND_FORWARD_EN.
module operand_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_ra1,
    input  logic [REG_W-1:0]    id_ra2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_regwrite,
    input  logic                id_memtoreg,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [DATA_W-1:0]   rd1,
    input  logic [DATA_W-1:0]   rd2,
    input  logic                mem_valid,
    input  logic                mem_regwrite,
    input  logic [REG_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]   mem_result,
    input  logic                wb_valid,
    input  logic                wb_regwrite,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]   wb_result,
    input  logic                flush,
    output logic                stall_id,
    output logic                ex_valid,
    output logic                ex_regwrite,
    output logic                ex_memtoreg,
    output logic [REG_W-1:0]    ex_rd,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [DATA_W-1:0]   ex_opa,
    output logic [DATA_W-1:0]   ex_opb,
    output logic [CNT_W-1:0]    stall_count
);

    // Handshake: id_valid marks a real instruction; stall_id=1 means the
    // instruction is not taken this edge and decode must hold it unchanged.
    // flush outranks both and kills whatever would enter EX.

    ex_bundle_t        ex_q;
    fwd_sel_t          fwd1, fwd2;
    logic              raw_stall;
    logic [DATA_W-1:0] opa_sel, opb_sel;

    hazard_detect u_hazard (
        .id_valid     (id_valid),
        .id_ra1       (id_ra1),
        .id_ra2       (id_ra2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .ex_valid     (ex_q.valid),
        .ex_regwrite  (ex_q.regwrite),
        .ex_memtoreg  (ex_q.memtoreg),
        .ex_rd        (ex_q.rd),
        .mem_valid    (mem_valid),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .fwd1         (fwd1),
        .fwd2         (fwd2),
        .stall        (raw_stall)
    );

    // Selects are constant FWD_RF when bypassing is compiled out.
    assign opa_sel  = sel_operand(fwd1, rd1, mem_result, wb_result);
    assign opb_sel  = sel_operand(fwd2, rd2, mem_result, wb_result);
    assign stall_id = raw_stall & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            stall_count <= '0;
        end else begin
            if (stall_id && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (flush || stall_id) begin
                ex_q <= '0;
            end else begin
                ex_q.valid    <= id_valid;
                ex_q.regwrite <= id_regwrite;
                ex_q.memtoreg <= id_memtoreg;
                ex_q.rd       <= id_rd;
                ex_q.ctrl     <= id_ctrl;
                ex_q.imm      <= id_imm;
                ex_q.opa      <= opa_sel;
                ex_q.opb      <= opb_sel;
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_rd       = ex_q.rd;
    assign ex_ctrl     = ex_q.ctrl;
    assign ex_imm      = ex_q.imm;
    assign ex_opa      = ex_q.opa;
    assign ex_opb      = ex_q.opb;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: drivers push the expected EX bundle and
// counter per cycle; a monitor pops and compares after each rising edge.
module tb_operand_stage;
    import pipe_pkg::*;

    localparam int CNT_W = 4;
    localparam int EXP_W = $bits(ex_bundle_t) + CNT_W;
`ifdef OPERAND_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 id_valid, id_use1, id_use2, id_regwrite, id_memtoreg;
    logic [REG_W-1:0]     id_ra1, id_ra2, id_rd;
    logic [EX_CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0]    id_imm, rd1, rd2;
    logic                 mem_valid, mem_regwrite, wb_valid, wb_regwrite, flush;
    logic [REG_W-1:0]     mem_rd, wb_rd;
    logic [DATA_W-1:0]    mem_result, wb_result;
    logic                 stall_id, ex_valid, ex_regwrite, ex_memtoreg;
    logic [REG_W-1:0]     ex_rd;
    logic [EX_CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0]    ex_imm, ex_opa, ex_opb;
    logic [CNT_W-1:0]     stall_count;

    logic [EXP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               step_no  = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    ex_bundle_t bub;
    ex_bundle_t ld7;

    operand_stage #(.CTRL_W(EX_CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .id_ctrl(id_ctrl), .id_imm(id_imm), .rd1(rd1), .rd2(rd2),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_result(wb_result), .flush(flush),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_imm(ex_imm), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .stall_count(stall_count)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic ex_bundle_t mk(
        input logic v, input logic rw, input logic mt, input logic [3:0] rd,
        input logic [9:0] c, input logic [31:0] imm, input logic [31:0] a,
        input logic [31:0] b
    );
        ex_bundle_t r;
        r = '{valid: v, regwrite: rw, memtoreg: mt, rd: rd, ctrl: c,
              imm: imm, opa: a, opb: b};
        return r;
    endfunction

    task automatic clr();
        id_valid = 0; id_use1 = 0; id_use2 = 0; id_regwrite = 0; id_memtoreg = 0;
        id_ra1 = '0; id_ra2 = '0; id_rd = '0; id_ctrl = '0; id_imm = '0;
        rd1 = '0; rd2 = '0; flush = 0;
        mem_valid = 0; mem_regwrite = 0; mem_rd = '0; mem_result = '0;
        wb_valid = 0; wb_regwrite = 0; wb_rd = '0; wb_result = '0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input logic e_stall, input ex_bundle_t e_bun);
        #1;
        n_checks++;
        if (stall_id !== e_stall) begin
            n_fail++;
            $display("FAIL stall_id step %0d: got %b expected %b", step_no, stall_id, e_stall);
        end
        if (reset)
            exp_cnt = '0;
        else if (e_stall && exp_cnt != {CNT_W{1'b1}})
            exp_cnt = exp_cnt + 1'b1;
        exp_q.push_back({e_bun, exp_cnt});
        step_no++;
        @(negedge clk);
    endtask

    task automatic load7();
        clr();
        id_valid = 1; id_rd = 4'd7; id_regwrite = 1; id_memtoreg = 1;
        id_ctrl = 10'h003; id_imm = 32'h10; rd1 = 32'h5; rd2 = 32'h6;
        step(1'b0, ld7);
    endtask

    task automatic dep7();
        clr();
        id_valid = 1; id_ra1 = 4'd7; id_use1 = 1; rd1 = 32'h77;
        id_rd = 4'd9; id_regwrite = 1; id_ctrl = 10'h001; id_imm = 32'h2; rd2 = 32'h88;
    endtask

    // Scoreboard monitor
    always begin
        logic [EXP_W-1:0] e;
        ex_bundle_t       act;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{valid: ex_valid, regwrite: ex_regwrite, memtoreg: ex_memtoreg,
                    rd: ex_rd, ctrl: ex_ctrl, imm: ex_imm, opa: ex_opa, opb: ex_opb};
            n_checks++;
            if (act !== e[EXP_W-1:CNT_W]) begin
                n_fail++;
                $display("FAIL ex_bundle t=%0t: got %h expected %h", $time, act, e[EXP_W-1:CNT_W]);
            end
            n_checks++;
            if (stall_count !== e[CNT_W-1:0]) begin
                n_fail++;
                $display("FAIL stall_count t=%0t: got %0d expected %0d", $time, stall_count, e[CNT_W-1:0]);
            end
        end
    end

    initial begin
        bub = '0;
        ld7 = mk(1, 1, 1, 4'd7, 10'h003, 32'h10, 32'h5, 32'h6);
        reset = 1;
        clr();
        @(negedge clk);

        // reset with a WB hazard present: stall_id held low, EX cleared
        id_valid = 1; id_ra1 = 4'd2; id_use1 = 1; rd1 = 32'h55;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 4'd2;
        step(1'b0, bub);
        reset = 0;

        // back-to-back ALU dependency through EX/MEM
        clr();
        id_valid = 1; id_ra1 = 4'd3; id_use1 = 1; rd1 = 32'h11;
        id_ra2 = 4'd1; id_use2 = 1; rd2 = 32'h22;
        id_rd = 4'd4; id_regwrite = 1; id_ctrl = 10'h155; id_imm = 32'h1234;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 4'd3; mem_result = 32'hAA;
        step(!FWD, FWD ? mk(1, 1, 0, 4'd4, 10'h155, 32'h1234, 32'hAA, 32'h22) : bub);
        clr(); step(1'b0, bub);

        // double producer: EX/MEM wins over MEM/WB
        id_valid = 1; id_ra1 = 4'd6; id_use1 = 1; rd1 = 32'h66;
        id_ra2 = 4'd5; id_use2 = 1; rd2 = 32'h99;
        id_rd = 4'd8; id_regwrite = 1; id_ctrl = 10'h00F;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 4'd5; mem_result = 32'h1;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 4'd5; wb_result = 32'h2;
        step(!FWD, FWD ? mk(1, 1, 0, 4'd8, 10'h00F, 32'h0, 32'h66, 32'h1) : bub);
        clr(); step(1'b0, bub);

        // load-use: one bubble, then load result arrives via MEM, then WB
        load7();
        dep7(); step(1'b1, bub);
        mem_valid = 1; mem_regwrite = 1; mem_rd = 4'd7; mem_result = 32'hCAFE;
        step(!FWD, FWD ? mk(1, 1, 0, 4'd9, 10'h001, 32'h2, 32'hCAFE, 32'h88) : bub);
        mem_valid = 0; mem_regwrite = 0;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 4'd7; wb_result = 32'hCAFE;
        step(!FWD, FWD ? mk(1, 1, 0, 4'd9, 10'h001, 32'h2, 32'hCAFE, 32'h88) : bub);
        wb_valid = 0; wb_regwrite = 0; rd1 = 32'hCAFE;
        step(1'b0, mk(1, 1, 0, 4'd9, 10'h001, 32'h2, 32'hCAFE, 32'h88));
        clr(); step(1'b0, bub);

        // r15 source is never forwarded or stalled on
        id_valid = 1; id_ra1 = 4'hF; id_use1 = 1; rd1 = 32'h108;
        id_ra2 = 4'd0; id_use2 = 1; rd2 = 32'h42;
        id_rd = 4'd1; id_regwrite = 1; id_ctrl = 10'h2AA; id_imm = 32'hFFFF_FFFF;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 4'hF; mem_result = 32'hDEAD;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 4'hF; wb_result = 32'hBEEF;
        step(1'b0, mk(1, 1, 0, 4'd1, 10'h2AA, 32'hFFFF_FFFF, 32'h108, 32'h42));

        // flush during load-use: flush wins, bubble, counter unchanged
        load7();
        dep7(); flush = 1; step(1'b0, bub);

        // sources matching a load but not used do not stall
        clr();
        id_valid = 1; id_rd = 4'd10; id_regwrite = 1; id_memtoreg = 1;
        step(1'b0, mk(1, 1, 1, 4'd10, 10'h0, 32'h0, 32'h0, 32'h0));
        clr();
        id_valid = 1; id_ra1 = 4'd10; id_ra2 = 4'd10; rd1 = 32'h3; rd2 = 32'h4;
        step(1'b0, mk(1, 0, 0, 4'd0, 10'h0, 32'h0, 32'h3, 32'h4));

        // load-use on source 2
        clr();
        id_valid = 1; id_rd = 4'd12; id_regwrite = 1; id_memtoreg = 1;
        step(1'b0, mk(1, 1, 1, 4'd12, 10'h0, 32'h0, 32'h0, 32'h0));
        clr();
        id_valid = 1; id_ra2 = 4'd12; id_use2 = 1; rd2 = 32'h9;
        step(1'b1, bub);

        // no stall when the consumer is not a valid instruction
        load7();
        dep7(); id_valid = 0; id_rd = 4'd0; id_regwrite = 0; id_ctrl = '0; id_imm = '0; rd2 = '0;
        step(1'b0, mk(0, 0, 0, 4'd0, 10'h0, 32'h0, 32'h77, 32'h0));

        // drive the counter into saturation
        for (int i = 0; i < 16; i++) begin
            load7();
            dep7(); step(1'b1, bub);
        end

        // reset during a stall clears EX and the counter
        load7();
        dep7(); reset = 1; step(1'b0, bub);
        reset = 0;
        step(1'b0, mk(1, 1, 0, 4'd9, 10'h001, 32'h2, 32'h77, 32'h88));
        clr(); step(1'b0, bub);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
